// File: rtl/timer_pkg.sv
// Shared state encoding and digit limits for the game elapsed-time counter.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    MAX   = 2'd3
  } state_t;

  localparam logic [3:0] MOD10 = 4'd9;
  localparam logic [3:0] MOD6  = 4'd5;

  localparam int unsigned TICK_DIV_DEFAULT = 1000000;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the elapsed-time chain; wraps at TERMINAL and carries on the same cycle.
module bcd_digit_counter
  import timer_pkg::*;
#(
  parameter logic [3:0] TERMINAL = MOD10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_d;
  logic [3:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (inc) begin
      q_d = (q_q == TERMINAL) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc & (q_q == TERMINAL);

endmodule

// File: rtl/game_timer_bcd.sv
// Game elapsed-time counter HH:MM:SS.ss in BCD with start/pause/clear control.
// state | meaning: IDLE held/zeroed, RUN counting, PAUSE frozen, MAX saturated at 99:59:59.99
module game_timer_bcd
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEFAULT,
  parameter bit          AUTO_UPPER = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       upper_req,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic [3:0] digit5,
  output logic [3:0] digit6,
  output logic [3:0] digit7,
  output logic       running,
  output logic       maxed,
  output logic       show_upper
);

  localparam int unsigned     PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state_d, state_q;
  logic [PW-1:0] presc_d, presc_q;
  logic          running_d, running_q;
  logic          maxed_d, maxed_q;
  logic          show_upper_d, show_upper_q;

  logic       tick, inc0, clr_dig, upper_max, at_max, near_max;
  logic [6:0] carry;
  logic       carry_unused;

  assign tick      = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign upper_max = (digit7 == MOD10) && (digit6 == MOD10) && (digit5 == MOD6) &&
                     (digit4 == MOD10) && (digit3 == MOD6) && (digit2 == MOD10) &&
                     (digit1 == MOD10);
  assign at_max    = upper_max && (digit0 == MOD10);
  assign near_max  = upper_max && (digit0 == 4'd8);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    inc0    = 1'b0;
    clr_dig = 1'b0;
    if (clear) begin
      state_d = IDLE;
      presc_d = '0;
      clr_dig = 1'b1;
    end else if (pause) begin
      if (state_q == RUN) state_d = PAUSE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        PAUSE: begin
          if (start) state_d = RUN;
        end
        RUN: begin
          if (tick) begin
            presc_d = '0;
            // The tick that lands on 99:59:59.99 is also the one that enters MAX.
            if (at_max) begin
              state_d = MAX;
            end else begin
              inc0 = 1'b1;
              if (near_max) state_d = MAX;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: ;
      endcase
    end
    running_d    = (state_d == RUN);
    maxed_d      = (state_d == MAX);
    show_upper_d = upper_req | (AUTO_UPPER & (|{digit4, digit5, digit6, digit7}));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      running_q    <= 1'b0;
      maxed_q      <= 1'b0;
      show_upper_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      running_q    <= running_d;
      maxed_q      <= maxed_d;
      show_upper_q <= show_upper_d;
    end
  end

  bcd_digit_counter #(.TERMINAL(MOD10)) u_d0 (.clk(clk), .rst_n(rst_n), .clr(clr_dig),
    .inc(inc0),     .q(digit0), .carry(carry[0]));
  bcd_digit_counter #(.TERMINAL(MOD10)) u_d1 (.clk(clk), .rst_n(rst_n), .clr(clr_dig),
    .inc(carry[0]), .q(digit1), .carry(carry[1]));
  bcd_digit_counter #(.TERMINAL(MOD10)) u_d2 (.clk(clk), .rst_n(rst_n), .clr(clr_dig),
    .inc(carry[1]), .q(digit2), .carry(carry[2]));
  bcd_digit_counter #(.TERMINAL(MOD6))  u_d3 (.clk(clk), .rst_n(rst_n), .clr(clr_dig),
    .inc(carry[2]), .q(digit3), .carry(carry[3]));
  bcd_digit_counter #(.TERMINAL(MOD10)) u_d4 (.clk(clk), .rst_n(rst_n), .clr(clr_dig),
    .inc(carry[3]), .q(digit4), .carry(carry[4]));
  bcd_digit_counter #(.TERMINAL(MOD6))  u_d5 (.clk(clk), .rst_n(rst_n), .clr(clr_dig),
    .inc(carry[4]), .q(digit5), .carry(carry[5]));
  bcd_digit_counter #(.TERMINAL(MOD10)) u_d6 (.clk(clk), .rst_n(rst_n), .clr(clr_dig),
    .inc(carry[5]), .q(digit6), .carry(carry[6]));
  bcd_digit_counter #(.TERMINAL(MOD10)) u_d7 (.clk(clk), .rst_n(rst_n), .clr(clr_dig),
    .inc(carry[6]), .q(digit7), .carry(carry_unused));

  assign running    = running_q;
  assign maxed      = maxed_q;
  assign show_upper = show_upper_q;

endmodule
